piso: RTL and testbench

- Parallel-load register: captures a WIDTH-bit input word on a clock edge when load is asserted and presents the whole word in parallel on its output.
- Output holds its value until the next load or reset.
- Used as a simple storage/staging register in sequential datapaths. Single clock domain, no handshaking beyond the load strobe.

---
 rtl/piso.sv | 18 +
 tb/tb_piso.sv | 77 +++++++
 2 files changed

// File: rtl/piso.sv
// piso: parallel-load register; in/ld load a WIDTH-bit word, rst forces RST_VAL, out holds it; clk rising edge only
module piso #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic [WIDTH-1:0] in,
  input  logic             rst,
  input  logic             clk,
  input  logic             ld,
  output logic [WIDTH-1:0] out
);
  logic [WIDTH-1:0] out_q, out_d;
  always_comb out_d = ld ? in : out_q;
  always_ff @(posedge clk)
    if (rst) out_q <= RST_VAL;
    else     out_q <= out_d;
  assign out = out_q;
endmodule

// File: tb/tb_piso.sv
// tb_piso: random and directed check of piso against a last-accepted-word model
module tb_piso;
  logic       clk = 0;
  logic       rst = 0;
  logic       ld = 0;
  logic [3:0] din = 0;
  logic [3:0] dout;
  logic [3:0] held;
  bit         known = 0;
  int         checks = 0;
  int         failures = 0;

  piso #(.WIDTH(4), .RST_VAL(4'h0)) dut (.in(din), .rst(rst), .clk(clk), .ld(ld), .out(dout));

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic l, input logic [3:0] d);
    @(negedge clk);
    rst = r;
    ld  = l;
    din = d;
    @(posedge clk);
    if (r) begin
      held  = 4'h0;
      known = 1;
    end else if (l) held = d;
  endtask

  task automatic lit(input string name, input logic [3:0] want);
    #1;
    checks++;
    if (dout !== want) begin
      failures++;
      $display("FAIL %s out=%h required=%h", name, dout, want);
    end
  endtask

  always @(negedge clk)
    if (known) begin
      checks++;
      if (dout !== held) begin
        failures++;
        $display("FAIL model t=%0t out=%h required=%h", $time, dout, held);
      end
    end

  initial begin
    step(1, 0, 4'h0);                lit("reset", 4'h0);
    step(0, 1, 4'hC);                lit("load_c", 4'hC);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 4'($urandom));      lit("hold_c", 4'hC);
    end
    step(0, 1, 4'hF);                lit("load_f", 4'hF);
    step(0, 0, 4'h3);                lit("idle_f", 4'hF);
    step(0, 1, 4'h0);                lit("load_0", 4'h0);
    step(0, 1, 4'h5);                lit("load_5", 4'h5);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 4'(i * 5 + 2));     lit("hold_5_toggle", 4'h5);
    end
    step(0, 1, 4'h1);                lit("load_1", 4'h1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 4'hE);              lit("hold_1", 4'h1);
    end
    step(0, 1, 4'h7);                lit("load_7", 4'h7);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 4'h9);              lit("hold_7", 4'h7);
    end
    step(1, 1, 4'hA);                lit("reset_priority", 4'h0);
    step(0, 1, 4'hA);                lit("load_after_rst", 4'hA);
    for (int i = 0; i < 600; i++)
      step($urandom_range(15) == 0, $urandom_range(1) == 1, 4'($urandom));
    step(0, 1, 4'hF);                lit("all_ones", 4'hF);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
